// File: rtl/instr_queue.sv
// instr_queue: in-order instruction queue between fetch and decode.
// The oldest entry is presented combinationally (first-word fall-through),
// and a NOP word is shown whenever the queue is empty.
// A flush discards all entries at the clock edge where it is sampled.
// Reset is asynchronous.
module instr_queue #(
  parameter int                 WIDTH = 32,
  parameter int                 DEPTH = 4,
  parameter logic [WIDTH-1:0]   NOP   = WIDTH'(32'h0000_0000),
  parameter int                 CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] instr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] instr_out,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wp_reg, wp_next;
  logic [AW-1:0] rp_reg, rp_next;
  logic [CW-1:0] count_reg, count_next;

  logic push;
  logic pop;

  // Handshake flags come from the stored state only.
  // This means no input can reach an output combinationally.
  assign in_ready  = (count_reg != FULL_CNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_reg;
  assign instr_out = out_valid ? mem[rp_reg] : NOP;

  // Next pointer/occupancy.
  // Flush overrides any push or pop in the same cycle.
  always_comb begin
    wp_next    = wp_reg;
    rp_next    = rp_reg;
    count_next = count_reg;
    if (flush) begin
      wp_next    = '0;
      rp_next    = '0;
      count_next = '0;
    end else begin
      if (push) wp_next = wp_reg + AW'(1);
      if (pop)  rp_next = rp_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy state.
  // Cleared immediately on reset, without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      wp_reg    <= wp_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
    end
  end

  // Entry storage.
  // A word offered during a flush is dropped.
  // Contents are never cleared: the empty state masks them with NOP.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wp_reg] <= instr_in;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue (DEPTH=4).
module tb_instr_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic        flush;
  logic [2:0]  count;

  int passed;
  int total;

  instr_queue #(.WIDTH(32), .DEPTH(4), .NOP(32'h0000_0000)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_in  (instr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .flush     (flush),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-16s observed=%08h expected=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"},  32'(count),     32'd0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_iready"}, 32'(in_ready),  32'd1);
    chk({tag, "_out"},    instr_out,      32'h0000_0000);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    instr_in  = '0;

    // Reset is asserted between edges and checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk_empty("rst_async");
    @(negedge clock);
    reset = 1'b0;
    step();
    chk_empty("rst_release");

    // Fill with decode stalled.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      instr_in = 32'h2008_0000 + 32'(i);
      step();
      if (i == 1) begin
        chk("fill1_out",    instr_out,     32'h2008_0001);
        chk("fill1_ovalid", 32'(out_valid), 32'd1);
      end
    end
    chk("full_count",  32'(count),    32'd4);
    chk("full_iready", 32'(in_ready), 32'd0);
    chk("full_out",    instr_out,     32'h2008_0001);
    instr_in = 32'h2008_0005;
    step();
    chk("fifth_count", 32'(count), 32'd4);
    chk("fifth_out",   instr_out,  32'h2008_0001);

    // Drain in order.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_out", instr_out, 32'h2008_0000 + 32'(i));
      step();
    end
    chk_empty("drained");

    // Streaming with wrap: each word is at the head one cycle after its push.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      instr_in = 32'(k);
      step();
      chk("stream_out",   instr_out,  32'(k));
      chk("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk_empty("stream_end");

    // Simultaneous push and pop at count=3.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in = 32'h0000_0011; step();
    instr_in = 32'h0000_0022; step();
    instr_in = 32'h0000_0033; step();
    chk("pp_pre_count", 32'(count), 32'd3);
    instr_in  = 32'hAAAA_0000;
    out_ready = 1'b1;
    chk("pp_popped", instr_out, 32'h0000_0011);
    step();
    chk("pp_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    chk("pp_drain1", instr_out, 32'h0000_0022); step();
    chk("pp_drain2", instr_out, 32'h0000_0033); step();
    chk("pp_drain3", instr_out, 32'hAAAA_0000); step();
    chk_empty("pp_end");

    // Flush with traffic on both sides.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in = 32'h0000_0044; step();
    instr_in = 32'h0000_0055; step();
    instr_in = 32'h0000_0066; step();
    chk("fl_pre_count", 32'(count), 32'd3);
    flush     = 1'b1;
    instr_in  = 32'hBEEF_0000;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_empty("flushed");
    in_valid = 1'b1;
    instr_in = 32'h0000_0077;
    step();
    in_valid = 1'b0;
    chk("fl_next_out",   instr_out,  32'h0000_0077);
    chk("fl_next_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    chk_empty("fl_end");

    // Reset pulse of half a cycle in mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in = 32'h0000_0088; step();
    instr_in = 32'h0000_0099; step();
    out_ready = 1'b1;
    instr_in  = 32'h0000_00AA;
    step();
    chk("mr_count", 32'(count), 32'd2);
    #3;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_empty("mr_reset");
    #4;
    reset    = 1'b0;
    in_valid = 1'b1;
    instr_in = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    chk("mr_head",  instr_out,  32'h1234_5678);
    chk("mr_count1", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    chk_empty("mr_alone");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
